// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Streaming 3x3 window generator. Takes a row-major 8-bit pixel
//             stream of one IMG_W x IMG_H frame and emits one fully populated
//             3x3 window per interior position. It uses two line buffers and a
//             3x3 register window.
//  Ports    : i_clk              - system clock, rising edge
//             i_rst              - asynchronous reset, active low
//             i_pixel            - incoming 8-bit unsigned pixel
//             i_pixel_valid      - pixel accepted this cycle (no backpressure)
//             i_sof              - start of frame, qualified by i_pixel_valid
//             o_pixel_data       - 3x3 window, byte k = r*3+c, r/c = 0 oldest
//             o_pixel_data_valid - one-cycle pulse per new window
//             o_frame_done       - one-cycle pulse on last pixel of a frame
//  Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel,
    input  logic        i_pixel_valid,
    input  logic        i_sof,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic [CW-1:0] MIN_COL  = CW'(2);
    localparam logic [RW-1:0] MIN_ROW  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    lb0 [IMG_W];   // previous row
    logic [7:0]    lb1 [IMG_W];   // row before previous
    logic [71:0]   win;

    logic          accept;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic [7:0]    top;
    logic [7:0]    mid;
    logic          at_last_col;
    logic          at_last_row;

    // A start-of-frame pulse overrides the counters so the stream resyncs to
    // (0,0) no matter where the previous frame stopped.
    always_comb begin
        accept      = i_pixel_valid;
        pos_col     = (i_sof) ? '0 : col;
        pos_row     = (i_sof) ? '0 : row;
        top         = lb1[pos_col];
        mid         = lb0[pos_col];
        at_last_col = (pos_col == LAST_COL);
        at_last_row = (pos_row == LAST_ROW);
    end

    // Position counters and output pulses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col                <= '0;
            row                <= '0;
            o_pixel_data_valid <= 1'b0;
            o_frame_done       <= 1'b0;
        end else begin
            o_pixel_data_valid <= accept && (pos_row >= MIN_ROW) && (pos_col >= MIN_COL);
            o_frame_done       <= accept && at_last_row && at_last_col;
            if (accept) begin
                if (at_last_col) begin
                    col <= '0;
                    row <= (at_last_row) ? '0 : pos_row + RW'(1);
                end else begin
                    col <= pos_col + CW'(1);
                    row <= pos_row;
                end
            end
        end
    end

    // Line buffers carry no reset: anything stale is overwritten during rows
    // 0 and 1 of a frame, which never produce a valid window.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1[pos_col] <= lb0[pos_col];
            lb0[pos_col] <= i_pixel;
        end
    end

    // Window shift: each row moves one column left and the new column
    // (top, mid, current pixel) lands in column 2.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            win <= '0;
        end else if (accept) begin
            win <= {i_pixel, win[71:64], win[63:56],
                    mid,     win[47:40], win[39:32],
                    top,     win[23:16], win[15:8]};
        end
    end

    assign o_pixel_data = win;

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 window generator that feeds the convolution engine's 72-bit `i_pixel_data` / `i_pixel_data_valid` input.
- Accepts a row-major 8-bit pixel stream of one IMG_W x IMG_H image (MNIST 28x28 by default).
- Uses two line buffers plus a 3x3 register window to emit one fully-populated window per valid interior position.
- Sits between the image loader and the conv block.

Parameters:
- IMG_W, 28, pixels per row; must be at least 3.
- IMG_H, 28, rows per frame; must be at least 3.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  reset, asynchronous, active-low (0 = reset).
- i_pixel  input  8  incoming pixel, unsigned.
- i_pixel_valid  input  1  i_pixel is accepted this cycle; no backpressure.
- i_sof  input  1  start of frame; qualified by i_pixel_valid.
- o_pixel_data  output  72  3x3 window. Byte k = bits [k*8+:8], k = r*3+c. r=0 is the oldest (top) row; c=0 is the oldest (left) column.
- o_pixel_data_valid  output  1  o_pixel_data holds a new window this cycle (single-cycle pulse per window).
- o_frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - col and row counters go to 0.
  - o_pixel_data, window registers, o_pixel_data_valid and o_frame_done go to 0.
  - Line-buffer contents are not reset; stale data is never emitted because of the row/col gating below.
- Accept:
  - Occurs on any cycle with i_pixel_valid=1. Cycles with i_pixel_valid=0 change no state except clearing the two output pulses.
- Position and counters:
  - The accepted pixel is at (row, col).
  - If i_sof=1 with i_pixel_valid=1, the pixel is forced to (0,0) regardless of the counters (resync). Counters then continue from (0,1).
  - col increments per accept. At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
- Line buffers: two buffers, LB0 and LB1, each IMG_W x 8, indexed by col. On accept of pixel p at col c:
  - top = LB1[c] (row-2), mid = LB0[c] (row-1), bot = p.
  - LB1[c] <= LB0[c]; LB0[c] <= p.
- Window registers:
  - Columns shift left: w[r][0] <= w[r][1], w[r][1] <= w[r][2].
  - New column loads: w[0][2] <= top, w[1][2] <= mid, w[2][2] <= bot.
  - o_pixel_data is driven directly from w. It holds its value between accepts.
- Valid:
  - o_pixel_data_valid <= accept && row>=2 && col>=2, using the position after any i_sof override.
  - Latency is 1 cycle: the window whose bottom-right is pixel (row, col) appears on the cycle after that pixel is accepted.
  - Windows never straddle a row boundary. After (row, IMG_W-1), the next valid follows (row+1, 2).
  - Exactly (IMG_H-2)*(IMG_W-2) valids per frame; 676 for 28x28.
- Frame done:
  - o_frame_done <= accept at (IMG_H-1, IMG_W-1).
  - It coincides with the last o_pixel_data_valid of the frame.
- i_sof mid-frame:
  - Abandons the current frame; no o_frame_done is issued for it.
  - Rows 0 and 1 of the new frame produce no valids. Old line-buffer data is overwritten before it can be used.
- Gaps: idle cycles (i_pixel_valid=0) anywhere, including mid-row, stall the generator. Output values are unaffected by gaps.
- Arithmetic: none; data is pure 8-bit movement. Counter widths are $clog2 of IMG_W and IMG_H.

Test Plan:
- First window, default params:
  - Stimulus: i_sof on the first pixel; pixel value = (row*28+col) mod 256; continuous valid.
  - Required: first o_pixel_data_valid occurs 1 cycle after accepting pixel index 58, with o_pixel_data = 72'h3A_39_38_1E_1D_1C_02_01_00.
- Full frame, 784 pixels:
  - Required: exactly 676 valid pulses, and no valid on the cycles following col=0 or col=1.
  - Required: o_frame_done is high on the same cycle as the 676th valid, with o_pixel_data = {p(27,27), p(27,26), p(27,25), ..., p(25,25)} mod 256.
- Gapped input: the same frame with i_pixel_valid toggled pseudo-randomly (about 50% duty) -> identical sequence of 676 windows; valid never asserted on idle-following cycles.
- Small image, IMG_W=5, IMG_H=4, pixel value = index 0..19:
  - Required: 6 windows.
  - Required: the first window is bytes {12,11,10,7,6,5,2,1,0}, listed from byte 8 down to byte 0.
  - Required: the last window is bytes {19,18,17,14,13,12,9,8,7}.
- Reset and resync:
  - Assert i_rst=0 mid-row 10: all outputs are 0 immediately (asynchronously).
  - Release reset and send a new frame with i_sof: the first valid follows its pixel (2,2), with correct contents.
  - Separately, an i_sof mid-frame without reset -> same first-window result, and no o_frame_done for the abandoned frame.
- Back-to-back frames with no idle cycle between them: the second frame's windows are correct and contain no old-frame bytes; o_frame_done pulses once per frame.
